// File: rtl/load_store_unit.sv
// RV32I load/store unit: sub-word loads by lane extraction, sub-word stores by read-modify-write.
// Optional LSU_MISALIGN_CHECK_EN: report misaligned halfword/word accesses as errors.
module load_store_unit #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_i,
   input  logic                  we_i,
   input  logic [2:0]            funct3_i,
   input  logic [DATA_WIDTH-1:0] addr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  err_o,
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic                  Mem_Write_o,
   output logic                  Mem_Read_o,
   output logic [DATA_WIDTH-1:0] Address_o,
   output logic [DATA_WIDTH-1:0] Write_Data_o,
   input  logic [DATA_WIDTH-1:0] Read_Data_i
);

   // Handshake: req_i is taken only in IDLE; done_o pulses for one cycle in RESP with err_o valid alongside.
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_RMW_RD = 3'd2,
      S_WRITE  = 3'd3,
      S_RESP   = 3'd4
   } state_t;

   state_t                state_q, state_d;
   logic                  we_q;
   logic [2:0]            f3_q;
   logic [DATA_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] merge_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  err_q;

   logic                  legal;
   logic                  misalign;
   logic                  acc_err;
   logic [7:0]            ld_byte;
   logic [15:0]           ld_half;
   logic [DATA_WIDTH-1:0] ld_ext;
   logic [DATA_WIDTH-1:0] merged;

   always_comb begin
      legal    = 1'b0;
      misalign = 1'b0;
      if (we_i)
         legal = (funct3_i == 3'b000) || (funct3_i == 3'b001) || (funct3_i == 3'b010);
      else
         legal = (funct3_i == 3'b000) || (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                 (funct3_i == 3'b100) || (funct3_i == 3'b101);
`ifdef LSU_MISALIGN_CHECK_EN
      misalign = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                 ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
`else
      misalign = 1'b0;
`endif
      acc_err = !legal || misalign;
   end

   // Lane extraction always works on the forced-aligned position of the latched address.
   always_comb begin
      ld_byte = 8'h00;
      case (addr_q[1:0])
         2'b00:   ld_byte = Read_Data_i[7:0];
         2'b01:   ld_byte = Read_Data_i[15:8];
         2'b10:   ld_byte = Read_Data_i[23:16];
         default: ld_byte = Read_Data_i[31:24];
      endcase
      ld_half = addr_q[1] ? Read_Data_i[31:16] : Read_Data_i[15:0];
      case (f3_q)
         3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
         3'b100:  ld_ext = {24'h000000, ld_byte};
         3'b101:  ld_ext = {16'h0000, ld_half};
         default: ld_ext = Read_Data_i;
      endcase
   end

   // merge_q holds the store data until RMW_RD folds it into the fetched word.
   always_comb begin
      merged = Read_Data_i;
      if (f3_q[0])
         merged[{addr_q[1], 4'b0000} +: 16] = merge_q[15:0];
      else
         merged[{addr_q[1:0], 3'b000} +: 8] = merge_q[7:0];
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (req_i) begin
               if (acc_err)
                  state_d = S_RESP;
               else if (!we_i)
                  state_d = S_LOAD;
               else if (funct3_i[1:0] == 2'b10)
                  state_d = S_WRITE;
               else
                  state_d = S_RMW_RD;
            end
         end
         S_LOAD:   state_d = S_RESP;
         S_RMW_RD: state_d = S_WRITE;
         S_WRITE:  state_d = S_RESP;
         S_RESP:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         we_q    <= 1'b0;
         f3_q    <= 3'b000;
         addr_q  <= '0;
         merge_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            S_IDLE: begin
               if (req_i) begin
                  we_q    <= we_i;
                  f3_q    <= funct3_i;
                  addr_q  <= addr_i;
                  merge_q <= wdata_i;
                  err_q   <= acc_err;
                  if (acc_err && !we_i)
                     rdata_q <= '0;
               end
            end
            S_LOAD:   rdata_q <= ld_ext;
            S_RMW_RD: merge_q <= merged;
            default: ;
         endcase
      end
   end

   always_comb begin
      busy_o       = (state_q != S_IDLE);
      done_o       = (state_q == S_RESP);
      err_o        = (state_q == S_RESP) && err_q;
      rdata_o      = rdata_q;
      Mem_Read_o   = (state_q == S_LOAD) || (state_q == S_RMW_RD);
      Mem_Write_o  = (state_q == S_WRITE) && we_q;
      Address_o    = '0;
      Write_Data_o = '0;
      if ((state_q == S_LOAD) || (state_q == S_RMW_RD) || (state_q == S_WRITE))
         Address_o = {addr_q[DATA_WIDTH-1:2], 2'b00};
      if (state_q == S_WRITE)
         Write_Data_o = merge_q;
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Bus initiator between the core's execute stage and the word-only data memory.
- Takes one load or store request at a time and handles RV32I sub-word accesses: LB/LH/LW/LBU/LHU and SB/SH/SW.
- Loads use lane extraction plus sign or zero extension. Sub-word stores use a read-modify-write sequence.
- Drives the memory's write-enable, read-enable, address and write-data inputs, and consumes its combinational read data.

Parameters:
- DATA_WIDTH, 32, width of data and address buses. Only 32 is supported.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- req_i  in  1  request strobe; sampled only in IDLE
- we_i  in  1  1 = store, 0 = load
- funct3_i  in  3  RV32I size/sign field
- addr_i  in  DATA_WIDTH  byte address
- wdata_i  in  DATA_WIDTH  store data; low bits are used for SB/SH
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  valid with done_o; misaligned or illegal access
- rdata_o  out  DATA_WIDTH  extended load result
- Mem_Write_o  out  1  memory write enable
- Mem_Read_o  out  1  memory read enable
- Address_o  out  DATA_WIDTH  word-aligned address {addr[31:2],2'b00}
- Write_Data_o  out  DATA_WIDTH  full word to memory
- Read_Data_i  in  DATA_WIDTH  memory read word; combinational, zero when Mem_Read_o is low

Behaviour:
- Reset (reset==0 at a clock edge):
  - State goes to IDLE.
  - All outputs and internal registers go to 0.
  - An in-flight operation is abandoned, and no write is issued afterwards.
- States: IDLE, LOAD, RMW_RD, WRITE, RESP.
- IDLE, when req_i==1:
  - Latch we, funct3, addr and wdata.
  - Legality check:
    - Legal loads: funct3 000/001/010/100/101. Legal stores: funct3 000/001/010.
    - Misaligned: halfword with addr[0]==1, or word with addr[1:0]!=0.
  - Illegal or misaligned → RESP with the error flag set. No memory access is made.
  - Legal load → LOAD.
  - SW → WRITE, with the merge register set to wdata.
  - SB/SH → RMW_RD.
- req_i is ignored while busy_o==1.
- LOAD:
  - Mem_Read_o=1.
  - Extract the lane from Read_Data_i: byte = addr[1:0]; half = addr[1] (0 selects bits 15:0, 1 selects 31:16).
  - Sign-extend for LB/LH, zero-extend for LBU/LHU.
  - Register the result into rdata_o, then go to RESP.
- RMW_RD:
  - Mem_Read_o=1.
  - Merge register = Read_Data_i with the addressed byte/half replaced by wdata[7:0] or wdata[15:0].
  - Go to WRITE.
- WRITE:
  - Mem_Write_o=1 and Write_Data_o = merge register.
  - The memory commits the word on this clock edge. Go to RESP.
- RESP:
  - done_o=1 for this cycle, with err_o set as latched. Go to IDLE.
  - busy_o is still 1 in RESP, so a new request can be accepted one cycle after done_o.
- Memory-side drive rules:
  - Address_o is driven from the latched address in LOAD, RMW_RD and WRITE, and is 0 otherwise.
  - Write_Data_o is 0 outside WRITE.
  - Mem_Read_o and Mem_Write_o are never high in the same cycle.
- Latency from the cycle req_i is accepted to the done_o cycle:
  - LW/LH/LB/LHU/LBU: 2
  - SW: 2
  - SB/SH: 3
  - Error: 1
- rdata_o:
  - Updates only when a load completes and holds otherwise.
  - An errored load sets rdata_o to 0.
  - Stores do not change rdata_o.
- err_o is 0 whenever done_o is 0.

Optional Feature:
- Macro: LSU_MISALIGN_CHECK_EN.
- Defined: alignment is checked as described above; misaligned accesses return err_o=1 with no memory access.
- Undefined: no alignment check.
  - Halfword accesses ignore addr[0]; word accesses ignore addr[1:0].
  - The access proceeds at the forced-aligned position.
  - err_o is raised only for illegal funct3.

Test Plan:
- Preload mem[word 4]=0x8081_F2A3. LB at 0x10 → done_o at +2, rdata_o=0xFFFF_FFA3. LBU at 0x11 → rdata_o=0x0000_00F2.
- Same word. LH at 0x12 → rdata_o=0xFFFF_8081. LHU at 0x12 → rdata_o=0x0000_8081. LW at 0x10 → rdata_o=0x8081_F2A3.
- mem[word 5]=0x1122_3344. SB wdata=0xAB at 0x16 → RMW_RD then WRITE, done at +3, mem=0x11AB_3344. Then SH wdata=0xBEEF at 0x14 → mem=0x11AB_BEEF.
- SW at 0x22 with LSU_MISALIGN_CHECK_EN defined → done_o at +1, err_o=1, Mem_Write_o never asserted. With the macro undefined → word at 0x20 is written.
- Illegal funct3: load funct3=011, or store funct3=100 → err_o=1 and memory untouched.
- Assert reset low during RMW_RD of an SB → next cycle IDLE, all outputs 0, target word unchanged. req_i pulsed while busy_o=1 → ignored, no extra done_o.
